// File: rtl/meta_tag_array_if.sv
// meta_tag_array_if: write, lookup and response channels of the cache tag store.
interface meta_tag_array_if #(
  parameter int N_SETS = 64,
  parameter int N_WAYS = 4,
  parameter int TAG_BITS = 20
);
  localparam int IDX_BITS = $clog2(N_SETS);
  logic write_valid;
  logic write_ready;
  logic [IDX_BITS-1:0] write_bits_idx;
  logic [N_WAYS-1:0] write_bits_way_en;
  logic [TAG_BITS-1:0] write_bits_tag;
  logic read_valid;
  logic read_ready;
  logic [IDX_BITS-1:0] read_bits_idx;
  logic resp_valid;
  logic [N_WAYS*TAG_BITS-1:0] resp_bits_tags;
  logic init_done;
  modport master (
    output write_valid, write_bits_idx, write_bits_way_en, write_bits_tag, read_valid, read_bits_idx,
    input write_ready, read_ready, resp_valid, resp_bits_tags, init_done
  );
  modport slave (
    input write_valid, write_bits_idx, write_bits_way_en, write_bits_tag, read_valid, read_bits_idx,
    output write_ready, read_ready, resp_valid, resp_bits_tags, init_done
  );
endinterface

// File: rtl/meta_tag_array.sv
// meta_tag_array: single-ported set-associative tag store with post-reset zeroing sweep.
module meta_tag_array #(
  parameter int N_SETS = 64,
  parameter int N_WAYS = 4,
  parameter int TAG_BITS = 20
) (
  input logic clock,
  input logic reset,
  meta_tag_array_if.slave io
);
  localparam int IDX_BITS = $clog2(N_SETS);
  typedef enum logic {INIT, READY} state_t;
  state_t state, state_nxt;
  logic [IDX_BITS-1:0] counter;
  logic [N_WAYS-1:0][TAG_BITS-1:0] mem [N_SETS];
  logic wr_fire, rd_fire;
  // readiness is gated by reset so nothing is accepted in the reset cycle
  always_comb begin
    state_nxt = (state == INIT && &counter) ? READY : state;
    io.write_ready = reset && state == READY;
    io.read_ready = reset && state == READY && !io.write_valid;
    io.init_done = state == READY;
    wr_fire = io.write_valid && io.write_ready;
    rd_fire = io.read_valid && io.read_ready;
  end
  always_ff @(posedge clock)
    if (!reset) state <= INIT;
    else state <= state_nxt;
  always_ff @(posedge clock)
    if (!reset) begin
      counter <= '0;
      io.resp_valid <= 1'b0;
      io.resp_bits_tags <= '0;
    end else begin
      if (state == INIT) counter <= counter + 1'b1;
      io.resp_valid <= rd_fire;
      if (rd_fire) io.resp_bits_tags <= mem[io.read_bits_idx];
    end
  always_ff @(posedge clock)
    for (int w = 0; w < N_WAYS; w++)
      if (state == INIT) mem[counter][w] <= '0;
      else if (wr_fire && io.write_bits_way_en[w]) mem[io.write_bits_idx][w] <= io.write_bits_tag;
endmodule

// File: tb/tb_meta_tag_array.sv
// tb_meta_tag_array: randomized and directed checks of meta_tag_array against an array model.
module tb_meta_tag_array;
  localparam int NS = 64;
  localparam int NW = 4;
  localparam int TB = 20;
  localparam int RW = NW * TB;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  meta_tag_array_if #(.N_SETS(NS), .N_WAYS(NW), .TAG_BITS(TB)) io ();
  meta_tag_array #(.N_SETS(NS), .N_WAYS(NW), .TAG_BITS(TB)) dut (.clock(clock), .reset(reset), .io(io));
  int errors = 0;
  int checks = 0;
  logic [TB-1:0] m_mem [NS][NW];
  bit m_ready = 0;
  int m_left = NS;
  bit m_rv = 0;
  logic [RW-1:0] m_tags = '0;
  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [RW-1:0] row(input int idx);
    logic [RW-1:0] r;
    for (int w = 0; w < NW; w++) r[w*TB +: TB] = m_mem[idx][w];
    return r;
  endfunction
  // one clock: drive, check readiness, advance model across the edge, check outputs
  task automatic cycle(input bit rn, input bit wv, input int widx, input logic [NW-1:0] wen,
                       input logic [TB-1:0] tag, input bit rv, input int ridx);
    bit wf, rf;
    reset = rn;
    io.write_valid = wv;
    io.write_bits_idx = widx[5:0];
    io.write_bits_way_en = wen;
    io.write_bits_tag = tag;
    io.read_valid = rv;
    io.read_bits_idx = ridx[5:0];
    #1;
    wf = rn && m_ready && wv;
    rf = rn && m_ready && rv && !wv;
    check("write_ready", RW'(io.write_ready), RW'(rn && m_ready));
    check("read_ready", RW'(io.read_ready), RW'(rn && m_ready && !wv));
    @(posedge clock);
    if (!rn) begin
      m_ready = 0;
      m_left = NS;
      m_rv = 0;
      m_tags = '0;
      for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) m_mem[s][w] = '0;
    end else begin
      if (!m_ready) begin
        m_left--;
        if (m_left == 0) m_ready = 1;
      end
      m_rv = rf;
      if (rf) m_tags = row(ridx);
      if (wf) for (int w = 0; w < NW; w++) if (wen[w]) m_mem[widx][w] = tag;
    end
    #1;
    check("resp_valid", RW'(io.resp_valid), RW'(m_rv));
    check("resp_tags", io.resp_bits_tags, m_tags);
    check("init_done", RW'(io.init_done), RW'(m_ready));
  endtask
  task automatic idle();
    cycle(1, 0, 0, '0, '0, 0, 0);
  endtask
  initial begin
    repeat (3) cycle(0, 0, 0, '0, '0, 0, 0);
    for (int i = 0; i < NS; i++) cycle(1, 0, 0, '0, '0, 1, 0);
    check("init_done_at_64", RW'(io.init_done), RW'(1));
    cycle(1, 0, 0, '0, '0, 1, 0);
    check("sweep_zero_idx0", io.resp_bits_tags, '0);
    cycle(1, 1, 5, 4'b0101, 20'hABCDE, 0, 0);
    cycle(1, 0, 0, '0, '0, 1, 5);
    check("partial_write", io.resp_bits_tags, {20'h0, 20'hABCDE, 20'h0, 20'hABCDE});
    idle();
    cycle(1, 1, 9, 4'b1000, 20'h12345, 1, 9);
    cycle(1, 0, 0, '0, '0, 1, 9);
    check("write_priority_way3", RW'(io.resp_bits_tags[3*TB +: TB]), RW'(20'h12345));
    cycle(1, 1, 7, 4'b0010, 20'hFFFFF, 0, 0);
    cycle(1, 1, 7, 4'b0000, 20'h00000, 0, 0);
    cycle(1, 0, 0, '0, '0, 1, 7);
    check("way_en_zero_noop", RW'(io.resp_bits_tags[TB +: TB]), RW'(20'hFFFFF));
    for (int i = 0; i < NS; i++) cycle(1, 0, 0, '0, '0, 1, i);
    idle();
    repeat (400) begin
      cycle($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15),
            NW'($urandom), TB'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 15));
    end
    for (int i = 0; i < 2 * NS && !m_ready; i++) idle();
    cycle(1, 1, 5, 4'b1111, 20'h5A5A5, 0, 0);
    cycle(0, 0, 0, '0, '0, 1, 5);
    check("reset_drops_read", RW'(io.resp_valid), RW'(0));
    check("reset_init_done", RW'(io.init_done), RW'(0));
    for (int i = 0; i < NS; i++) idle();
    cycle(1, 0, 0, '0, '0, 1, 5);
    check("resweep_zero", io.resp_bits_tags, '0);
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/meta_tag_array.md
# meta_tag_array

Set-associative L1 data-cache tag store sitting directly downstream of the two-input metadata-write arbiter. It consumes the arbiter's winning write request (set index, way enable, tag) and serves tag lookups for the cache pipeline over a separate read channel with a fixed one-cycle response. Storage is single-ported: writes take priority over reads. After reset, an internal sweep zeroes every tag before either channel accepts traffic.

## Interface
- nSets, 64, number of sets; power of two, ≥2; idxBits = log2(nSets)
- nWays, 4, number of ways
- tagBits, 20, tag width
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- io_write_valid  in  1  write request present (from arbiter io_out_valid)
- io_write_ready  out  1  write accepted this cycle when high with valid
- io_write_bits_idx  in  idxBits  set to write
- io_write_bits_way_en  in  nWays  one bit per way; every set bit is written
- io_write_bits_tag  in  tagBits  tag value written to each enabled way
- io_read_valid  in  1  lookup request present
- io_read_ready  out  1  lookup accepted this cycle when high with valid
- io_read_bits_idx  in  idxBits  set to look up
- io_resp_valid  out  1  lookup result valid; single-cycle pulse, no backpressure
- io_resp_bits_tags  out  nWays*tagBits  way w in bits [w*tagBits +: tagBits]
- io_init_done  out  1  high once the reset sweep has finished

## Operation
- States: INIT, READY. Reset (reset low at an edge) → INIT, sweep counter = 0.
- INIT: each cycle writes all-zero tags to every way of set `counter`; counter increments; after writing set nSets-1 → READY. Counter is idxBits wide; its wrap to 0 is the exit condition.
- INIT: io_write_ready = 0, io_read_ready = 0; requests stall, none dropped.
- READY: io_write_ready = 1 (always).
- READY: io_read_ready = ~io_write_valid (write priority; single port).
- Write fire (valid & ready): for each w with way_en[w] = 1, array[idx][w] ← tag; ways with way_en[w] = 0 unchanged. way_en = 0 fires and is a no-op.
- Read fire: array[idx] is captured into the response register; io_resp_valid = 1 on the next cycle only.
- A read and a write never both fire in one cycle.
- io_resp_bits_tags holds its last value while io_resp_valid = 0.
- No ways are hit-compared here; comparison belongs to the consumer.

## Timing
- Reset values: io_write_ready 0, io_read_ready 0, io_resp_valid 0, io_resp_bits_tags 0, io_init_done 0.
- Sweep takes exactly nSets cycles. With reset released before edge E0, INIT writes occur at edges E0..E(nSets-1). io_init_done, io_write_ready and io_read_ready first go high after E(nSets-1), i.e. 64 cycles for the defaults.
- Read latency is 1: read fires at edge N; tags appear, with io_resp_valid = 1, for the cycle following edge N.
- Write-then-read: a write firing at edge N is visible to a read firing at edge N+1 or later. There is no same-cycle bypass, because the two cannot co-fire.
- Back-to-back reads with io_write_valid = 0 sustain 1 response per cycle.
- Reset mid-operation: a pending response is discarded (io_resp_valid 0 next cycle), state returns to INIT, counter returns to 0, and the full sweep repeats.
- A write or read presented in the reset cycle is not accepted.

## Test plan
- Reset release, read valid held from cycle 0 → io_read_ready stays 0 for 64 cycles. io_init_done rises at cycle 64. Read of idx 0 then returns all four tags = 0x00000.
- Write idx 5, way_en 4'b0101, tag 0xABCDE; then read idx 5 next cycle → tags {way3 0, way2 0xABCDE, way1 0, way0 0xABCDE}, resp_valid exactly one cycle later.
- Write and read both valid in the same READY cycle (idx 9, way_en 4'b1000, tag 0x12345) → io_read_ready 0, write fires. Read fires next cycle and returns way3 = 0x12345.
- Streaming reads of idx 0..63 with no writes → 64 consecutive resp_valid cycles, each returning the tags of its idx in order.
- write_valid with way_en 0 at idx 7 after pre-writing way1 = 0xFFFFF → read returns way1 still 0xFFFFF.
- Reset asserted on the cycle a read fires → no resp_valid, io_init_done 0. A re-sweep of 64 cycles follows; tags previously written read back 0 afterwards.
